// File: rtl/chan_join_reduce_pipe.sv
// Join one word per channel, bitwise-reduce under a runtime mode, and drain
// through a STAGES-deep valid/ready pipe. CHAN_JOIN_PERF_EN adds perf_count.

module chan_join_hold_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             fire,
  output logic             in_ready,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_data
);
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             take;

  always_comb begin
    in_ready     = ~hold_valid_q | fire;
    take         = in_valid & in_ready;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    // A refill in the firing cycle wins over the clear
    if (take) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign hold_valid = hold_valid_q;
  assign hold_data  = hold_data_q;
endmodule

module chan_join_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 3,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
`ifdef CHAN_JOIN_PERF_EN
  ,
  output logic [CNT_W-1:0]        perf_count
`endif
);
  logic [NUM_CH-1:0]             hold_valid;
  logic [NUM_CH-1:0][WIDTH-1:0]  hold_data;
  logic                          fire;
  logic [WIDTH-1:0]              red;

  logic [STAGES-1:0]             vld_pipe_q, vld_pipe_d;
  logic [STAGES-1:0][WIDTH-1:0]  s_data_q, s_data_d;
  logic [STAGES-1:0]             can_accept;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    chan_join_hold_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data[i*WIDTH +: WIDTH]),
      .in_valid  (in_valid[i]),
      .fire      (fire),
      .in_ready  (in_ready[i]),
      .hold_valid(hold_valid[i]),
      .hold_data (hold_data[i])
    );
  end

  always_comb begin
    red = (mode == 2'b00) ? '1 : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode)
        2'b00:   red = red & hold_data[i];
        2'b01:   red = red | hold_data[i];
        default: red = red ^ hold_data[i];
      endcase
    end
    if (mode == 2'b11) red = ~red;
  end

  // Ready ripples from out_ready back to stage 0; top stage first
  always_comb begin
    can_accept = '0;
    can_accept[STAGES-1] = ~vld_pipe_q[STAGES-1] | out_ready;
    for (int k = STAGES-2; k >= 0; k--)
      can_accept[k] = ~vld_pipe_q[k] | can_accept[k+1];
  end

  assign fire = (&hold_valid) & can_accept[0];

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s_data_d   = s_data_q;
    if (can_accept[0]) begin
      vld_pipe_d[0] = fire;
      if (fire) s_data_d[0] = red;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (can_accept[k]) begin
        vld_pipe_d[k] = vld_pipe_q[k-1];
        if (vld_pipe_q[k-1]) s_data_d[k] = s_data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s_data_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s_data_q   <= s_data_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES-1];
  assign out_data  = s_data_q[STAGES-1];
  assign busy      = (|hold_valid) | (|vld_pipe_q);

`ifdef CHAN_JOIN_PERF_EN
  logic [CNT_W-1:0] perf_count_q, perf_count_d;

  always_comb begin
    perf_count_d = perf_count_q;
    if (out_valid & out_ready) perf_count_d = perf_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_count_q <= '0;
    else     perf_count_q <= perf_count_d;
  end

  assign perf_count = perf_count_q;
`endif
endmodule

// File: tb/tb_chan_join_reduce_pipe.sv
// Scoreboard bench for chan_join_reduce_pipe: expected reductions queued at
// drive time, popped when an output transfer is observed.
module tb_chan_join_reduce_pipe;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 3;
  localparam int STAGES = 2;
`ifdef CHAN_JOIN_PERF_EN
  localparam int CNT_W  = 4;
`else
  localparam int CNT_W  = 16;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [1:0]              mode;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
`ifdef CHAN_JOIN_PERF_EN
  logic [CNT_W-1:0]        perf_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int out_cnt = 0;
  logic [WIDTH-1:0] sb[$];

  chan_join_reduce_pipe #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef CHAN_JOIN_PERF_EN
    ,
    .perf_count(perf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [1:0] m, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    case (m)
      2'b00:   return a & b & c;
      2'b01:   return a | b | c;
      2'b10:   return a ^ b ^ c;
      default: return ~(a ^ b ^ c);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_cnt++;
      if (sb.size() == 0) chk("unexpected_out", 32'(out_data), 32'hDEAD);
      else                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
    end
  end

  // Called just after a rising edge; leaves the caller just after the next one
  task automatic drive_set(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    in_data  = {c, b, a};
    in_valid = '1;
    sb.push_back(model(mode, a, b, c));
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [WIDTH-1:0] pat_a[4] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
  logic [WIDTH-1:0] exp_m[4] = '{8'h30, 8'hFF, 8'h33, 8'hCC};
  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mode = 2'b00; in_data = '0; in_valid = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // First cycle after reset
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 32'b111);
    @(posedge clk); #1;

    // Each mode, latency 1+STAGES; also cross-check the model against constants
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      chk("model_const", 32'(model(mode, pat_a[m], 8'h3C, 8'hFF)), 32'(exp_m[m]));
      drive_set(pat_a[m], 8'h3C, 8'hFF);
      @(negedge clk); chk("lat_c1", 32'(out_valid), 0);
      @(posedge clk); @(negedge clk); chk("lat_c2", 32'(out_valid), 0);
      @(posedge clk); @(negedge clk); chk("lat_c3", 32'(out_valid), 1);
      @(posedge clk); #1;
      repeat (2) @(posedge clk); #1;
    end
    chk("modes_drained", 32'(sb.size()), 0);

    // Partial arrival: ch0/1 in cycle 0, ch2 in cycle 4
    mode = 2'b00;
    in_data = {8'h00, 8'h0F, 8'hAA};
    in_valid = 3'b011;
    @(posedge clk); #1;
    in_valid = '0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 4) begin
        in_data = {8'hF3, 8'h00, 8'h00};
        in_valid = 3'b100;
        sb.push_back(model(mode, 8'hAA, 8'h0F, 8'hF3));
      end
      @(negedge clk);
      if (c <= 4) chk("partial_in_ready", 32'(in_ready[1:0]), 0);
      chk("partial_out_valid", 32'(out_valid), (c == 7) ? 1 : 0);
      @(posedge clk); #1;
      in_valid = '0;
    end
    repeat (2) @(posedge clk); #1;

    // Stall then release: 5 sets, handshake-held on the input side
    mode = 2'b10;
    out_ready = 1'b0;
    base = out_cnt;
    fork
      begin
        for (int s = 0; s < 5; s++) begin
          logic [WIDTH-1:0] a, b, c;
          bit done;
          int tries;
          a = 8'(8'h11 * (s + 1)); b = 8'(8'h5A + s); c = 8'(s << 4);
          in_data = {c, b, a};
          in_valid = '1;
          done = 0; tries = 0;
          while (!done) begin
            @(negedge clk);
            if (&in_ready) begin
              sb.push_back(model(mode, a, b, c));
              done = 1;
            end
            @(posedge clk); #1;
            if (++tries > 60) begin
              chk("stall_send_timeout", 32'(s), 32'hFFFF);
              done = 1;
            end
          end
        end
        in_valid = '0;
      end
      begin
        repeat (6) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_queued", 32'(sb.size()), 3);
        chk("stall_head", 32'(out_data), 32'(sb[0]));
        @(negedge clk);
        chk("stall_stable", 32'(out_data), 32'(sb[0]));
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1 chk("release_burst", 32'(out_cnt - base), 5);
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("stall_drained", 32'(sb.size()), 0);

    // Reset with two words in flight
    mode = 2'b01;
    drive_set(8'h01, 8'h02, 8'h04);
    drive_set(8'h10, 8'h20, 8'h40);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = out_cnt;
    drive_set(8'h81, 8'h42, 8'h24);
    repeat (8) @(negedge clk);
    #1 chk("post_rst_one_out", 32'(out_cnt - base), 1);
    chk("post_rst_drained", 32'(sb.size()), 0);
    @(posedge clk); #1;

`ifdef CHAN_JOIN_PERF_EN
    do_reset();
    mode = 2'b00;
    for (int s = 0; s < 17; s++) drive_set(8'(s), 8'hFF, 8'hFF);
    repeat (6) @(posedge clk); #1;
    chk("perf_wrap", 32'(perf_count), 1);
`endif

    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/chan_join_reduce_pipe.md
Name: chan_join_reduce_pipe

Overview:
- Parametrised successor to the fixed three-block register/combine/register top level.
- Registers NUM_CH independent producer channels, joins one word from each, and bitwise-reduces them under a runtime mode (AND/OR/XOR/XNOR).
- Carries the result through a STAGES-deep valid/ready pipeline to one consumer.
- Sits between parallel datapath units and a common sink.

Parameters:
WIDTH, 8, data bits per channel and of the result
NUM_CH, 3, number of input channels (2..16)
STAGES, 2, output pipeline register stages (>=1)
CNT_W, 16, width of the optional transaction counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
mode  input  2  reduction select: 00 AND, 01 OR, 10 XOR, 11 XNOR
in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready
out_data  output  WIDTH  reduced result
out_valid  output  1  result valid
out_ready  input  1  consumer ready
busy  output  1  any holding register or stage occupied
perf_count  output  CNT_W  completed output transfers (only when CHAN_JOIN_PERF_EN is defined)

Behaviour:
- Reset: all hold_valid=0, hold_data=0, stage valids=0, stage data=0. This gives out_valid=0, out_data=0, busy=0, and in_ready all 1 in the first cycle after reset.
- Reset mid-operation discards all held and in-flight words; no partial result is emitted.
- Holding registers: one entry per channel. Channel i transfer when in_valid[i]&in_ready[i]; data is captured next edge.
- fire = &hold_valid & s0_can_accept.
- in_ready[i] = ~hold_valid[i] | fire. Same-cycle refill while firing is allowed, giving full throughput.
- s[k]_can_accept = ~s[k]_valid | s[k]_advance. The last stage advances on out_ready.
- The ready chain is combinational from out_ready to in_ready.
- On fire:
  - s0_data <= reduction of all NUM_CH hold_data using mode sampled in the fire cycle.
  - hold_valid bits not simultaneously refilled clear.
- XNOR is defined as the bitwise complement of the XOR reduction.
- Stage k copies stage k-1 when it advances. out_data/out_valid come straight from the last stage register.
- Latency: if all channels transfer in cycle t with an empty pipe, fire occurs in t+1 and out_valid rises in t+1+STAGES.
- Stall: with out_ready=0, out_valid and out_data hold stable until accepted. The pipe fills to STAGES entries, then the holds fill, then in_ready drops.
- Partial arrival: a channel that holds a word keeps in_ready=0 until all channels hold. Other channels may still be accepted.
- mode change while words are in flight affects only fires after the change.
- busy = |hold_valid | any stage valid.

Optional Feature:
- Macro CHAN_JOIN_PERF_EN.
- Defined:
  - perf_count port exists.
  - Increments by 1 on each out_valid&out_ready and wraps 2^CNT_W-1 -> 0.
  - Resets to 0 on rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, rst 2 cycles -> out_valid=0, out_data=0x00, busy=0, in_ready=3'b111 in first post-reset cycle.
- mode=00, all channels present 0xF0, 0x3C, 0xFF in cycle 0, out_ready=1 -> out_valid=1, out_data=0x30 in cycle 3. Then repeat with mode=01 -> 0xFF; mode=10 -> 0x33; mode=11 -> 0xCC.
- Channels 0 and 1 valid in cycle 0, channel 2 valid only in cycle 4 -> in_ready[1:0]=0 during cycles 1-4. No output until cycle 7.
- out_ready=0, 5 back-to-back full sets -> 2 stage entries plus 3 holds filled, all in_ready=0. Release out_ready -> 5 results in order, one per cycle, none lost or duplicated.
- Assert rst with 2 words in flight -> out_valid=0 next cycle. The first post-reset set yields exactly one output.
- With CHAN_JOIN_PERF_EN and CNT_W=4, 17 accepted outputs -> perf_count=1 (wrapped).
